// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package uart_tx_arbiter_pkg;

  // Sequencer states; the encodings are fixed so other UART control blocks can decode them.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_e;

  localparam int DEF_MAX_BURST = 8;
  localparam int DEF_TIMEOUT   = 4096;

  // One-hot expansion of a requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle around the UART TX arbiter.
// Latency: n/a (wires only).
// Backpressure: a byte moves when validN & ready[N]; the next byte waits for tx_done_tick.
interface uart_tx_arbiter_if;
  logic [1:0] req;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       valid0;
  logic       valid1;
  logic       last0;
  logic       last1;
  logic [1:0] ready;
  logic [1:0] gnt;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       tx_done_tick;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;

  // Requesters and the transmitter side drive the inputs of the arbiter.
  modport master (
    output req, data0, data1, valid0, valid1, last0, last1, tx_done_tick, err_clr,
    input  ready, gnt, tx_start, tx_din, busy, timeout_err
  );

  // The arbiter itself.
  modport slave (
    input  req, data0, data1, valid0, valid1, last0, last1, tx_done_tick, err_clr,
    output ready, gnt, tx_start, tx_din, busy, timeout_err
  );
endinterface

// File: rtl/uart_watchdog.sv
// Loadable down-counter; expired is high while enabled with the count at zero.
// Latency: load on clr, then one decrement per enabled cycle; expired is combinational.
// Backpressure: none; en simply freezes the count when low.
module uart_watchdog #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load wins over counting; the count parks at zero once it gets there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the UART transmitter between two byte requesters, in bursts.
// Latency: req -> gnt 1 cycle; accepted byte -> tx_start 1 cycle; done tick -> next GRANT 1 cycle.
// Backpressure: ready only in GRANT; each byte blocks until tx_done_tick or the watchdog fires.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic             gnt_idx_q, gnt_idx_d;
  logic             ptr_q, ptr_d;
  logic [7:0]       tx_din_q, tx_din_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;
  logic       timeout_hit;
  logic       sel_req;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;

  // Watchdog is armed while the byte goes out, so it starts full on the first WAIT cycle.
  assign wd_en = (state_q == ST_WAIT);

  uart_watchdog #(
    .WIDTH (WD_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wd_clr),
    .en       (wd_en),
    .load_val (WD_LOAD),
    .expired  (wd_expired)
  );

  // Steer the granted requester's handshake into the sequencer.
  always_comb begin
    sel_req   = gnt_idx_q ? bus.req[1] : bus.req[0];
    sel_valid = gnt_idx_q ? bus.valid1 : bus.valid0;
    sel_last  = gnt_idx_q ? bus.last1  : bus.last0;
    sel_data  = gnt_idx_q ? bus.data1  : bus.data0;
  end

  // Next-state, grant choice, datapath capture and the sticky watchdog flag.
  always_comb begin
    state_d       = state_q;
    gnt_idx_d     = gnt_idx_q;
    ptr_d         = ptr_q;
    tx_din_d      = tx_din_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    wd_clr        = 1'b0;
    timeout_hit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          state_d = ST_GRANT;
          case (bus.req)
            2'b01:   gnt_idx_d = 1'b0;
            2'b10:   gnt_idx_d = 1'b1;
            default: gnt_idx_d = ptr_q;
          endcase
        end
      end
      ST_GRANT: begin
        // A valid byte takes priority over a simultaneous request drop.
        if (sel_valid) begin
          tx_din_d = sel_data;
          last_d   = sel_last;
          cnt_d    = cnt_q + 1'b1;
          state_d  = ST_SEND;
        end else if (!sel_req) begin
          state_d = ST_RELEASE;
        end
      end
      ST_SEND: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A real done tick beats an expiry landing in the same cycle.
        if (bus.tx_done_tick) begin
          if (last_q || (cnt_q == MAX_CNT) || !sel_req) begin
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_GRANT;
          end
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_d     = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        ptr_d   = ~gnt_idx_q;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Setting the flag overrides a clear in the same cycle.
    if (bus.err_clr) begin
      timeout_err_d = 1'b0;
    end
    if (timeout_hit) begin
      timeout_err_d = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gnt_idx_q     <= 1'b0;
      ptr_q         <= 1'b0;
      tx_din_q      <= 8'h00;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_idx_q     <= gnt_idx_d;
      ptr_q         <= ptr_d;
      tx_din_q      <= tx_din_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Outputs decode from state only, so they never combinationally depend on requester inputs.
  always_comb begin
    bus.gnt         = 2'b00;
    bus.ready       = 2'b00;
    bus.tx_start    = (state_q == ST_SEND);
    bus.tx_din      = tx_din_q;
    bus.busy        = (state_q != ST_IDLE);
    bus.timeout_err = timeout_err_q;
    if ((state_q == ST_GRANT) || (state_q == ST_SEND) || (state_q == ST_WAIT)) begin
      bus.gnt = onehot2(gnt_idx_q);
    end
    if (state_q == ST_GRANT) begin
      bus.ready = onehot2(gnt_idx_q);
    end
  end

endmodule
